ioctl_upload_reader: RTL and testbench

- Responder for the HPS ioctl upload direction, the reverse of the ROM download path. It answers each HPS byte read request with a byte fetched from SDRAM, or from MF2 RAM when the optional feature is built in.
- Reuses the download page map, so the HPS can read back the ROM/RAM banks that were written at boot.
- Sits in emu beside the boot loader and drives a read-only SDRAM request port. The top level muxes this port onto the sdram controller while `ioctl_upload` is high.

---
 rtl/ioctl_upload_reader.sv | 195 +++++++++++++++++++
 tb/tb_ioctl_upload_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader
// Answers HPS ioctl upload read requests, one byte at a time, by fetching the
// byte from SDRAM through a read-only request port. It uses the same page map
// as the ROM download path, so the HPS can read back the banks written at boot.
// Optional MF2 RAM source is built in when UPLOAD_MF2_EN is defined.
//
// Ports:
//   clk_sys, reset      system clock, synchronous active-high reset
//   ce_ref              SDRAM slot strobe (one pulse per 16 clk_sys)
//   ioctl_upload        HPS upload session active
//   ioctl_rd/addr       one-cycle read request and its byte address
//   ioctl_din/wait      returned byte, high while a request is outstanding
//   mem_rd/addr/bank    SDRAM read request
//   mem_dout            SDRAM data, valid at the ce_ref after mem_rd
//   busy                FSM not idle
//   mf2_a/mf2_q         MF2 RAM address/data (UPLOAD_MF2_EN only)
module ioctl_upload_reader #(
    parameter int         TIMEOUT = 64,
    parameter logic [7:0] FILL    = 8'hFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_ref,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic        mem_rd,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_bank,
    input  logic [7:0]  mem_dout,
    output logic        busy
`ifdef UPLOAD_MF2_EN
    ,
    output logic [12:0] mf2_a,
    input  logic [7:0]  mf2_q
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SLOT,
        READ
`ifdef UPLOAD_MF2_EN
        ,
        MF2
`endif
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    din_n;
    logic          wait_n, rd_n;
    logic [22:0]   addr_n;
    logic [1:0]    bank_n;

    // Page decode
    logic [10:0] page;
    logic        map_sd;
    logic [8:0]  map_hi;
    assign page = ioctl_addr[24:14];

    always_comb begin
        map_sd = 1'b1;
        map_hi = 9'h000;
        case (page)
            11'd0, 11'd4: map_hi = 9'h000;
            11'd1, 11'd5: map_hi = 9'h100;
            11'd2, 11'd6: map_hi = 9'h107;
            11'd3, 11'd7: map_hi = 9'h1FF;
            default:      map_sd = 1'b0;
        endcase
    end

`ifdef UPLOAD_MF2_EN
    logic        map_mf2;
    logic [12:0] mf2_a_n;
    // MF2 RAM is 8 KiB, so the upper half of page 8 is unmapped.
    assign map_mf2 = (page == 11'd8) && !ioctl_addr[13];
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        din_n   = ioctl_din;
        wait_n  = ioctl_wait;
        rd_n    = mem_rd;
        addr_n  = mem_addr;
        bank_n  = mem_bank;
`ifdef UPLOAD_MF2_EN
        mf2_a_n = mf2_a;
`endif
        if (!ioctl_upload) begin
            // Session ended: drop everything, keep the last returned byte.
            state_n = IDLE;
            cnt_n   = '0;
            wait_n  = 1'b0;
            rd_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ioctl_wait) begin
                        // wait high while idle marks a pending unmapped reply
                        din_n  = FILL;
                        wait_n = 1'b0;
                    end else if (ioctl_rd) begin
                        wait_n = 1'b1;
                        if (map_sd) begin
                            state_n = SLOT;
                            cnt_n   = '0;
                            addr_n  = {map_hi, ioctl_addr[13:0]};
                            bank_n  = {1'b0, page[2]};
                        end
`ifdef UPLOAD_MF2_EN
                        else if (map_mf2) begin
                            state_n = MF2;
                            cnt_n   = '0;
                            mf2_a_n = ioctl_addr[12:0];
                        end
`endif
                    end
                end
                SLOT, READ: begin
                    // Counter spans both states so a stalled ce_ref still
                    // releases the HPS after TIMEOUT cycles.
                    if (cnt == CW'(TIMEOUT - 1)) begin
                        state_n = IDLE;
                        rd_n    = 1'b0;
                        din_n   = FILL;
                        wait_n  = 1'b0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                        if (ce_ref) begin
                            if (state == SLOT) begin
                                rd_n    = 1'b1;
                                state_n = READ;
                            end else begin
                                din_n   = mem_dout;
                                rd_n    = 1'b0;
                                wait_n  = 1'b0;
                                state_n = IDLE;
                            end
                        end
                    end
                end
`ifdef UPLOAD_MF2_EN
                MF2: begin
                    // mf2_a registers on entry; the RAM needs one more edge
                    // before mf2_q reflects it.
                    if (cnt[0]) begin
                        din_n   = mf2_q;
                        wait_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = CW'(1);
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            mem_bank   <= '0;
`ifdef UPLOAD_MF2_EN
            mf2_a      <= '0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ioctl_din  <= din_n;
            ioctl_wait <= wait_n;
            mem_rd     <= rd_n;
            mem_addr   <= addr_n;
            mem_bank   <= bank_n;
`ifdef UPLOAD_MF2_EN
            mf2_a      <= mf2_a_n;
`endif
        end
    end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: table of read requests plus hand sequences
// for timeout, abort, ignored requests and reset mid-request.
module tb_ioctl_upload_reader;

    localparam logic [7:0] FILL = 8'hFF;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    wire  [7:0]  ioctl_din;
    wire         ioctl_wait, mem_rd, busy;
    wire  [22:0] mem_addr;
    wire  [1:0]  mem_bank;
    wire  [7:0]  mem_dout;
    wire         ce_ref;

    logic [3:0] ce_ph = 4'd0;
    logic       ce_stall = 1'b0;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) ce_ph <= ce_ph + 4'd1;
    assign ce_ref = (ce_ph == 4'd15) && !ce_stall;

    // SDRAM model: two seeded bytes, everything else a simple address hash.
    function automatic logic [7:0] sdram_byte(input logic [1:0] b, input logic [22:0] a);
        case ({b, a})
            {2'd0, 9'h100, 14'h0005}: return 8'h5A;
            {2'd1, 9'h1FF, 14'h0010}: return 8'hC3;
            default:                  return a[7:0] ^ {6'h0, b} ^ 8'h3C;
        endcase
    endfunction
    assign mem_dout = mem_rd ? sdram_byte(mem_bank, mem_addr) : 8'h00;

`ifdef UPLOAD_MF2_EN
    wire  [12:0] mf2_a;
    logic [7:0]  mf2_q = 8'h00;
    always @(posedge clk_sys) mf2_q <= (mf2_a == 13'h0123) ? 8'h77 : {3'b0, mf2_a[4:0]};
`endif

    ioctl_upload_reader dut (
        .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
        .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_bank(mem_bank),
        .mem_dout(mem_dout), .busy(busy)
`ifdef UPLOAD_MF2_EN
        , .mf2_a(mf2_a), .mf2_q(mf2_q)
`endif
    );

    // mem_rd burst monitor
    int          rd_bursts = 0, rd_len = 0, last_len = 0;
    logic        mem_rd_q = 1'b0;
    logic [22:0] seen_addr = '0;
    logic [1:0]  seen_bank = '0;
    always @(posedge clk_sys) begin
        mem_rd_q <= mem_rd;
        if (mem_rd && !mem_rd_q) rd_bursts <= rd_bursts + 1;
        if (mem_rd) begin
            rd_len    <= rd_len + 1;
            seen_addr <= mem_addr;
            seen_bank <= mem_bank;
        end else if (mem_rd_q) begin
            last_len <= rd_len;
            rd_len   <= 0;
        end
    end

    int total = 0, bad = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Drive a one-cycle rd; returns #1 after the edge that sampled it.
    task automatic issue(input logic [24:0] a);
        @(posedge clk_sys); #1;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b0;
    endtask

    // Wait (bounded) for wait to fall; lat counts edges since the rd edge.
    task automatic finish_req(input string name, input int lat0, output int lat);
        logic [7:0] e;
        lat = lat0;
        while (ioctl_wait && lat < 200) begin
            @(posedge clk_sys); #1;
            lat++;
        end
        if (ioctl_wait) begin
            total++; bad++;
            $display("FAIL %s_done: wait still high after %0d cycles", name, lat);
        end
        e = exp_q.pop_front();
        chk({name, "_din"}, ioctl_din, e);
    endtask

    task automatic wait_memrd(output int n);
        n = 0;
        while (!mem_rd && n < 40) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("memrd_seen", mem_rd, 1);
    endtask

    typedef struct {
        logic [24:0] addr;
        int          kind;   // 0 unmapped, 1 sdram, 2 mf2
        logic [7:0]  din;
        logic [22:0] maddr;
        logic [1:0]  bank;
    } vec_t;

    localparam int NV = 9;
    vec_t vec[NV];

    initial begin
        int lat, n, b0;
        string nm;

        vec[0] = '{25'h000_4005, 1, 8'h5A, 23'h400005, 2'd0};
        vec[1] = '{25'h001_C010, 1, 8'hC3, 23'h7FC010, 2'd1};
        vec[2] = '{25'h000_0123, 1, 8'h1F, 23'h000123, 2'd0};
        vec[3] = '{25'h001_8ABC, 1, 8'h81, 23'h41CABC, 2'd1};
        vec[4] = '{25'h000_8FFF, 1, 8'hC3, 23'h41CFFF, 2'd0};
        vec[5] = '{25'h002_4000, 0, FILL,  23'h0,      2'd0};
`ifdef UPLOAD_MF2_EN
        vec[6] = '{25'h002_0123, 2, 8'h77, 23'h0,      2'd0};
`else
        vec[6] = '{25'h002_0123, 0, FILL,  23'h0,      2'd0};
`endif
        vec[7] = '{25'h1FF_FFFF, 0, FILL,  23'h0,      2'd0};
        vec[8] = '{25'h000_FFFF, 1, 8'hC3, 23'h7FFFFF, 2'd0};

        // Reset and idle
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk_sys);
        #1;
        chk("rst_din", ioctl_din, 8'h00);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_memrd", mem_rd, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_bank", mem_bank, 0);
        chk("rst_busy", busy, 0);
        ioctl_upload = 1'b1;

        // Table of single requests
        for (int i = 0; i < NV; i++) begin
            nm = $sformatf("vec%0d", i);
            b0 = rd_bursts;
            exp_q.push_back(vec[i].din);
            issue(vec[i].addr);
            chk({nm, "_wait_hi"}, ioctl_wait, 1);
            finish_req(nm, 0, lat);
            @(posedge clk_sys); #1;
            if (vec[i].kind == 1) begin
                chk_rng({nm, "_lat"}, lat, 17, 32);
                chk({nm, "_bursts"}, rd_bursts, b0 + 1);
                chk({nm, "_rdlen"}, last_len, 16);
                chk({nm, "_maddr"}, seen_addr, vec[i].maddr);
                chk({nm, "_bank"}, seen_bank, vec[i].bank);
            end else begin
                chk({nm, "_lat"}, lat, (vec[i].kind == 2) ? 2 : 1);
                chk({nm, "_bursts"}, rd_bursts, b0);
`ifdef UPLOAD_MF2_EN
                if (vec[i].kind == 2) chk({nm, "_mf2a"}, mf2_a, 13'h0123);
`endif
            end
        end

        // Returned byte holds while idle
        repeat (10) @(posedge clk_sys);
        #1 chk("din_hold", ioctl_din, vec[NV-1].din);

        // Timeout with ce_ref stalled before the slot
        ce_stall = 1'b1;
        b0 = rd_bursts;
        exp_q.push_back(FILL);
        issue(25'h000_4005);
        finish_req("to_slot", 0, lat);
        chk("to_slot_lat", lat, 64);
        chk("to_slot_bursts", rd_bursts, b0);
        ce_stall = 1'b0;

        // Timeout with ce_ref stalled after mem_rd went out
        exp_q.push_back(FILL);
        issue(25'h000_8FFF);
        wait_memrd(n);
        ce_stall = 1'b1;
        finish_req("to_read", n, lat);
        chk("to_read_lat", lat, 64);
        chk("to_read_memrd", mem_rd, 0);
        ce_stall = 1'b0;

        // Abort in READ; a second rd while busy is ignored
        b0 = rd_bursts;
        issue(25'h000_4005);
        wait_memrd(n);
        ioctl_addr = 25'h001_C010;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b0;
        chk("busy_rd_maddr", mem_addr, 23'h400005);
        ioctl_upload = 1'b0;
        @(posedge clk_sys); #1;
        chk("abort_memrd", mem_rd, 0);
        chk("abort_wait", ioctl_wait, 0);
        chk("abort_busy", busy, 0);
        chk("abort_din", ioctl_din, FILL);
        repeat (40) @(posedge clk_sys);
        #1 chk("abort_bursts", rd_bursts, b0 + 1);

        // rd with upload low is ignored
        b0 = rd_bursts;
        issue(25'h000_4005);
        chk("noup_wait", ioctl_wait, 0);
        chk("noup_busy", busy, 0);
        repeat (40) @(posedge clk_sys);
        #1 chk("noup_bursts", rd_bursts, b0);
        ioctl_upload = 1'b1;

        // Reset mid-request
        issue(25'h001_C010);
        wait_memrd(n);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        chk("midrst_wait", ioctl_wait, 0);
        chk("midrst_memrd", mem_rd, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_din", ioctl_din, 8'h00);
        chk("midrst_maddr", mem_addr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
